// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, legal data-size codes, minimum bit period,
// and a helper that maps an illegal data size onto the 8-bit default.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    RECV      = 2'd2,
    STOP_CHK  = 2'd3
  } rx_state_t;

  localparam logic [3:0] DS_5 = 4'd5;
  localparam logic [3:0] DS_7 = 4'd7;
  localparam logic [3:0] DS_8 = 4'd8;

  // Below four clocks per bit the half-period sample point collapses.
  localparam int MIN_BIT_PERIOD = 4;

  // Only 5, 7 and 8 data bits are supported; anything else falls back to 8.
  function automatic logic [3:0] clamp_data_size(input logic [3:0] ds);
    logic [3:0] r;
    case (ds)
      DS_5, DS_7, DS_8: r = ds;
      default:          r = DS_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer: free-running counter with synchronous clear and period match flags.
// Latency: match flags are combinational from the count register (0 cycles).
// Backpressure: none; counts every cycle unless cleared.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - restart count at 0 on the next edge
//   period       - clocks per bit (already clamped by the caller)
//   half_match   - count has reached (period>>1)-1
//   full_match   - count has reached period-1
module rx_bit_timer #(
  parameter int BP_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [BP_W-1:0] period,
  output logic            half_match,
  output logic            full_match
);

  logic [BP_W-1:0] cnt;
  logic [BP_W-1:0] half_val;
  logic [BP_W-1:0] full_val;

  // Match on the last cycle of the interval so that clearing on the match
  // gives intervals of exactly half / full period.
  assign half_val = (period >> 1) - BP_W'(1);
  assign full_val = period - BP_W'(1);

  assign half_match = (cnt == half_val);
  assign full_match = (cnt == full_val);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + BP_W'(1);
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive controller: start-bit qualify, mid-bit strobes, stop check, status flags.
// Latency: first strobe bit_period+(bit_period>>1) clocks after the start edge; data_ready 2 clocks after the last strobe.
// Backpressure: none; an unread frame is overwritten and flagged via overrun_error.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   serial_in       - synchronised line input, idle high
//   bit_period      - clocks per bit (latched at start edge, min 4)
//   data_size       - data bits per frame 5/7/8 (latched at start edge)
//   stop_bit        - stop bit from the external 9-bit shift register
//   packet_data     - right-justified data from the external shift register
//   data_read       - host consumed rx_data; clears all status flags
//   shift_strobe    - one-cycle pulse per mid-bit sample (data bits + stop)
//   rx_data         - last good frame
//   data_ready, overrun_error, framing_error - sticky status flags
//   busy            - a frame is in progress
// Optional build macro: RX_GLITCH_FILTER_EN adds a 3-sample majority filter
// on serial_in (2 extra cycles of latency).
module rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int BP_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  input  logic [BP_W-1:0] bit_period,
  input  logic [3:0]      data_size,
  input  logic            stop_bit,
  input  logic [7:0]      packet_data,
  input  logic            data_read,
  output logic            shift_strobe,
  output logic [7:0]      rx_data,
  output logic            data_ready,
  output logic            overrun_error,
  output logic            framing_error,
  output logic            busy
);

  localparam logic [BP_W-1:0] BP_MIN = BP_W'(MIN_BIT_PERIOD);

  rx_state_t       state;
  rx_state_t       state_nxt;
  logic            line;
  logic            serial_in_q;
  logic            fall_edge;
  logic [BP_W-1:0] bp_q;
  logic [3:0]      ds_q;
  logic [3:0]      bit_cnt;
  logic            timer_clr;
  logic            half_match;
  logic            full_match;

`ifdef RX_GLITCH_FILTER_EN
  // Three registered samples; the majority ignores any single-cycle glitch.
  logic [2:0] filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 3'b111;
    end else begin
      filt_q <= {filt_q[1:0], serial_in};
    end
  end

  assign line = (filt_q[0] & filt_q[1]) |
                (filt_q[0] & filt_q[2]) |
                (filt_q[1] & filt_q[2]);
`else
  assign line = serial_in;
`endif

  assign fall_edge = serial_in_q & ~line;
  assign busy      = (state != IDLE);

  rx_bit_timer #(
    .BP_W (BP_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (timer_clr),
    .period     (bp_q),
    .half_match (half_match),
    .full_match (full_match)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and timer control.
  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    case (state)
      IDLE: begin
        // Hold the timer at zero so START_CHK begins counting from 0.
        timer_clr = 1'b1;
        if (fall_edge) begin
          state_nxt = START_CHK;
        end
      end
      START_CHK: begin
        if (half_match) begin
          timer_clr = 1'b1;
          // Line back high at mid start bit is a glitch, not a frame.
          state_nxt = line ? IDLE : RECV;
        end
      end
      RECV: begin
        if (full_match) begin
          timer_clr = 1'b1;
        end
        // Leave one cycle after the stop-bit strobe, giving the external
        // shift register that edge to capture the stop bit.
        if (shift_strobe && (bit_cnt == ds_q + 4'd1)) begin
          state_nxt = STOP_CHK;
        end
      end
      STOP_CHK: begin
        timer_clr = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        timer_clr = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame parameters, strobe generation and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      serial_in_q   <= 1'b1;
      bp_q          <= BP_MIN;
      ds_q          <= DS_8;
      bit_cnt       <= '0;
      shift_strobe  <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      serial_in_q  <= line;
      shift_strobe <= 1'b0;

      // Configuration is frozen for the whole frame.
      if ((state == IDLE) && fall_edge) begin
        bp_q    <= (bit_period < BP_MIN) ? BP_MIN : bit_period;
        ds_q    <= clamp_data_size(data_size);
        bit_cnt <= '0;
      end

      if ((state == RECV) && full_match) begin
        shift_strobe <= 1'b1;
        bit_cnt      <= bit_cnt + 4'd1;
      end

      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
        framing_error <= 1'b0;
      end

      // Placed after the read-clear so a same-cycle load takes priority.
      if (state == STOP_CHK) begin
        if (stop_bit) begin
          rx_data    <= packet_data;
          data_ready <= 1'b1;
          if (data_ready && !data_read) begin
            overrun_error <= 1'b1;
          end
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// Bench for rx_ctrl: directed frames with hand-computed results, scoreboard checked.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_ctrl;

  localparam int BP_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            serial_in;
  logic [BP_W-1:0] bit_period;
  logic [3:0]      data_size;
  logic            stop_bit;
  logic [7:0]      packet_data;
  logic            data_read;
  logic            shift_strobe;
  logic [7:0]      rx_data;
  logic            data_ready;
  logic            overrun_error;
  logic            framing_error;
  logic            busy;

  always #5 clk = ~clk;

  rx_ctrl #(.BP_W(BP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .bit_period    (bit_period),
    .data_size     (data_size),
    .stop_bit      (stop_bit),
    .packet_data   (packet_data),
    .data_read     (data_read),
    .shift_strobe  (shift_strobe),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // Downstream 9-bit shift register: LSB-first data, stop bit ends in [8].
  logic [8:0] sr = 9'h1FF;
  int         eff_ds = 8;
  always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
  assign stop_bit    = sr[8];
  assign packet_data = sr[7:0] >> (8 - eff_ds);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // op: 0 frame, 1 host read, 2 start glitch, 3 read with nothing pending
  typedef struct {
    int         op;
    int         bp_in;
    int         ds_in;
    int         bp;
    int         ds;
    logic [7:0] data;
    bit         stop;
    bit         rds;
    int         rst_at;
    logic [7:0] e_rx;
    bit         e_dr;
    bit         e_ov;
    bit         e_fe;
    int         e_str;
    int         e_first;
  } vec_t;

  typedef struct {
    bit         frame;
    logic [7:0] rx;
    bit         dr;
    bit         ov;
    bit         fe;
    int         strobes;
    int         first;
    int         gap;
  } exp_t;

  exp_t expq[$];
  bit   mon_en = 1'b0;

  // Monitor: an output event is a busy fall or any status/data change.
  initial begin
    int         cyc, t_rise, t_last, n_str, t_first, gmin, gmax, g;
    logic       busy_p;
    logic [10:0] snap, snap_p;
    bit         fell;
    exp_t       e;
    cyc = 0; t_rise = 0; t_last = 0; n_str = 0; t_first = -1; gmin = 0; gmax = 0;
    busy_p = 1'b0; snap_p = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (busy && !busy_p) begin
          n_str = 0; t_rise = cyc; t_first = -1; gmin = 1 << 30; gmax = 0;
        end
        if (shift_strobe) begin
          if (n_str == 0) t_first = cyc - t_rise;
          else begin
            g = cyc - t_last;
            if (g < gmin) gmin = g;
            if (g > gmax) gmax = g;
          end
          t_last = cyc;
          n_str++;
        end
        snap = {rx_data, data_ready, overrun_error, framing_error};
        fell = busy_p && !busy;
        if (fell || (snap !== snap_p)) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got rx=%0h flags=%0b busy_fell=%0d, expected no event",
                     snap[10:3], snap[2:0], fell);
          end else begin
            e = expq.pop_front();
            chk("event_kind", 32'(fell), 32'(e.frame));
            chk("rx_data", 32'(rx_data), 32'(e.rx));
            chk("data_ready", 32'(data_ready), 32'(e.dr));
            chk("overrun_error", 32'(overrun_error), 32'(e.ov));
            chk("framing_error", 32'(framing_error), 32'(e.fe));
            if (e.frame) begin
              chk("strobe_count", n_str, e.strobes);
              if (e.first >= 0) begin
                chk("first_strobe_delay", t_first, e.first);
                chk("strobe_gap_min", gmin, e.gap);
                chk("strobe_gap_max", gmax, e.gap);
                chk("last_strobe_to_idle", cyc - t_last, 2);
              end
            end
          end
        end
        busy_p = busy;
        snap_p = snap;
      end
    end
  end

  task automatic send_frame(input vec_t v);
    int   half, stop_c, total, b, n_seen;
    logic lv;
    half   = v.bp / 2;
    stop_c = v.bp * (v.ds + 1) + half + 2;
    total  = (v.ds + 2) * v.bp + 6;
    n_seen = 0;
    bit_period = BP_W'(v.bp_in);
    data_size  = 4'(v.ds_in);
    eff_ds     = v.ds;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      b = c / v.bp;
      if (b == 0)             lv = 1'b0;
      else if (b <= v.ds)     lv = v.data[b-1];
      else if (b == v.ds + 1) lv = v.stop;
      else                    lv = 1'b1;
      serial_in = lv;
      // Mid-frame config changes must not affect the frame in flight.
      if (c == 3) begin
        bit_period = BP_W'(v.bp_in + 5);
        data_size  = 4'd7;
      end
      data_read = v.rds && (c == stop_c);
      if (v.rst_at > 0 && shift_strobe) begin
        n_seen++;
        if (n_seen == v.rst_at) begin
          rst = 1'b1; serial_in = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk("rst_shift_strobe", 32'(shift_strobe), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_rx_data", 32'(rx_data), 0);
          chk("rst_flags", {29'd0, data_ready, overrun_error, framing_error}, 0);
          repeat (30) @(posedge clk);
          #1;
          chk("rst_no_late_strobe", 32'(shift_strobe), 0);
          break;
        end
      end
    end
    data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic host_read();
    @(posedge clk); #1; data_read = 1'b1;
    @(posedge clk); #1; data_read = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic glitch();
    bit_period = BP_W'(10);
    data_size  = 4'd8;
    for (int c = 0; c < 23; c++) begin
      @(posedge clk); #1;
      serial_in = (c < 3) ? 1'b0 : 1'b1;
    end
  endtask

  vec_t vt[17];

  initial begin
    exp_t e;
    vt = '{
      '{0, 10, 8, 10, 8, 8'hA5, 1, 0, 0, 8'hA5, 1, 0, 0, 9, 15},
      '{1,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0, 0,  0},
      '{0, 10, 5, 10, 5, 8'h15, 1, 0, 0, 8'h15, 1, 0, 0, 6, 15},
      '{1,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h15, 0, 0, 0, 0,  0},
      '{2, 10, 8, 10, 8, 8'h00, 0, 0, 0, 8'h15, 0, 0, 0, 0, -1},
      '{0, 10, 8, 10, 8, 8'h5A, 0, 0, 0, 8'h15, 0, 0, 1, 9, 15},
      '{1,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h15, 0, 0, 0, 0,  0},
      '{0, 10, 8, 10, 8, 8'h11, 1, 0, 0, 8'h11, 1, 0, 0, 9, 15},
      '{0, 10, 8, 10, 8, 8'h22, 1, 0, 0, 8'h22, 1, 1, 0, 9, 15},
      '{1,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h22, 0, 0, 0, 0,  0},
      '{0, 10, 8, 10, 8, 8'h33, 1, 0, 0, 8'h33, 1, 0, 0, 9, 15},
      '{0, 10, 8, 10, 8, 8'h44, 1, 1, 0, 8'h44, 1, 0, 0, 9, 15},
      '{1,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h44, 0, 0, 0, 0,  0},
      '{3,  0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h44, 0, 0, 0, 0,  0},
      '{0,  3, 6,  4, 8, 8'h96, 1, 0, 0, 8'h96, 1, 0, 0, 9,  6},
      '{0, 10, 8, 10, 8, 8'h77, 1, 0, 4, 8'h00, 0, 0, 0, 4, -1},
      '{0, 10, 8, 10, 8, 8'h3C, 1, 0, 0, 8'h3C, 1, 0, 0, 9, 15}
    };

    rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
    bit_period = BP_W'(10); data_size = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_shift_strobe", 32'(shift_strobe), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_flags", {29'd0, data_ready, overrun_error, framing_error}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    foreach (vt[i]) begin
      if (vt[i].op != 3) begin
        e.frame   = (vt[i].op != 1);
        e.rx      = vt[i].e_rx;
        e.dr      = vt[i].e_dr;
        e.ov      = vt[i].e_ov;
        e.fe      = vt[i].e_fe;
        e.strobes = vt[i].e_str;
        e.first   = vt[i].e_first;
        e.gap     = vt[i].bp;
        expq.push_back(e);
      end
      case (vt[i].op)
        0: send_frame(vt[i]);
        1: host_read();
        2: glitch();
        default: begin
          host_read();
          #1;
          chk("idle_read_data_ready", 32'(data_ready), 0);
          chk("idle_read_rx_data", 32'(rx_data), 32'(vt[i].e_rx));
        end
      endcase
      repeat (4) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
